// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, instruction memory and IF/ID bundle
interface fetch_stage_if;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    modport master (
        output stall, flush, redirect_pc, imem_instr,
        input  imem_pc, if_id_pc, if_id_instr, if_id_valid, halted, fetch_count
    );

    modport slave (
        input  stall, flush, redirect_pc, imem_instr,
        output imem_pc, if_id_pc, if_id_instr, if_id_valid, halted, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and self-loop halt
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h00000000,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013,
    parameter logic [31:0] HALT_INSTR = 32'h0000006f
) (
    input logic         clk,
    input logic         rst,
    fetch_stage_if.slave bus
);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_halt_pc;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;
    logic [31:0] r_fetch_count;

    logic [31:0] w_redirect_aligned;
    logic        w_is_halt_instr;
    logic [31:0] w_count_next;

    assign w_redirect_aligned = {bus.redirect_pc[31:2], 2'b00};
    assign w_is_halt_instr    = (bus.imem_instr == HALT_INSTR);
    assign w_count_next       = (r_fetch_count == 32'hFFFFFFFF) ? r_fetch_count
                                                                : r_fetch_count + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_halt_pc     <= 32'd0;
            r_if_id_pc    <= 32'd0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            r_fetch_count <= 32'd0;
        end else if (bus.flush) begin
            r_pc          <= w_redirect_aligned;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            // Redirecting back onto the halting self-loop keeps the core parked.
            if (r_state == ST_HALT && w_redirect_aligned != r_halt_pc)
                r_state <= ST_RUN;
        end else if (bus.stall) begin
            r_pc <= r_pc;
        end else if (r_state == ST_HALT) begin
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else begin
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= bus.imem_instr;
            r_if_id_valid <= 1'b1;
            r_fetch_count <= w_count_next;
            if (w_is_halt_instr) begin
                r_halt_pc <= r_pc;
                r_state   <= ST_HALT;
            end else begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    assign bus.imem_pc     = r_pc;
    assign bus.if_id_pc    = r_if_id_pc;
    assign bus.if_id_instr = r_if_id_instr;
    assign bus.if_id_valid = r_if_id_valid;
    assign bus.halted      = (r_state == ST_HALT);
    assign bus.fetch_count = r_fetch_count;
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic s, input logic [31:0] rpc, input logic [31:0] ins);
        bus.flush       = f;
        bus.stall       = s;
        bus.redirect_pc = rpc;
        bus.imem_instr  = ins;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},    bus.imem_pc, 32'h0);
        chk({tag, "_idpc"},  bus.if_id_pc, 32'h0);
        chk({tag, "_instr"}, bus.if_id_instr, 32'h13);
        chk({tag, "_valid"}, {31'd0, bus.if_id_valid}, 32'd0);
        chk({tag, "_halt"},  {31'd0, bus.halted}, 32'd0);
        chk({tag, "_cnt"},   bus.fetch_count, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h13);
        step();
        step();
        chk_reset("rst0");
        rst = 1'b0;

        drive(1'b0, 1'b0, 32'h0, 32'h00000413);
        step();
        chk("f0_idpc", bus.if_id_pc, 32'h0);
        chk("f0_instr", bus.if_id_instr, 32'h00000413);
        chk("f0_valid", {31'd0, bus.if_id_valid}, 32'd1);
        chk("f0_pc", bus.imem_pc, 32'h4);
        drive(1'b0, 1'b0, 32'h0, 32'h00000293);
        step();
        chk("f1_idpc", bus.if_id_pc, 32'h4);
        chk("f1_pc", bus.imem_pc, 32'h8);
        drive(1'b0, 1'b0, 32'h0, 32'h00400313);
        step();
        chk("f2_idpc", bus.if_id_pc, 32'h8);
        chk("f2_instr", bus.if_id_instr, 32'h00400313);
        chk("f2_pc", bus.imem_pc, 32'hC);
        chk("f2_cnt", bus.fetch_count, 32'd3);

        drive(1'b0, 1'b0, 32'h0, 32'h13);
        step();
        chk("f3_pc", bus.imem_pc, 32'h10);
        drive(1'b0, 1'b1, 32'h0, 32'h00500393);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_pc", bus.imem_pc, 32'h10);
            chk("stall_idpc", bus.if_id_pc, 32'hC);
            chk("stall_instr", bus.if_id_instr, 32'h13);
            chk("stall_cnt", bus.fetch_count, 32'd4);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h00500393);
        step();
        chk("unstall_pc", bus.imem_pc, 32'h14);
        chk("unstall_idpc", bus.if_id_pc, 32'h10);
        chk("unstall_instr", bus.if_id_instr, 32'h00500393);
        chk("unstall_cnt", bus.fetch_count, 32'd5);

        // Flush beats stall, and a halt encoding seen during flush is ignored.
        drive(1'b1, 1'b1, 32'h58, 32'h6f);
        step();
        chk("fl_pc", bus.imem_pc, 32'h58);
        chk("fl_instr", bus.if_id_instr, 32'h13);
        chk("fl_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("fl_idpc", bus.if_id_pc, 32'h10);
        chk("fl_halt", {31'd0, bus.halted}, 32'd0);
        chk("fl_cnt", bus.fetch_count, 32'd5);
        drive(1'b1, 1'b0, 32'h23, 32'h13);
        step();
        chk("fl_align", bus.imem_pc, 32'h20);

        drive(1'b1, 1'b0, 32'h60, 32'h13);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h6f);
        step();
        chk("h_halt", {31'd0, bus.halted}, 32'd1);
        chk("h_pc", bus.imem_pc, 32'h60);
        chk("h_idpc", bus.if_id_pc, 32'h60);
        chk("h_instr", bus.if_id_instr, 32'h6f);
        chk("h_valid", {31'd0, bus.if_id_valid}, 32'd1);
        chk("h_cnt", bus.fetch_count, 32'd6);
        step();
        chk("hb_pc", bus.imem_pc, 32'h60);
        chk("hb_instr", bus.if_id_instr, 32'h13);
        chk("hb_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("hb_cnt", bus.fetch_count, 32'd6);
        drive(1'b1, 1'b0, 32'h61, 32'h6f);
        step();
        chk("hsame_halt", {31'd0, bus.halted}, 32'd1);
        chk("hsame_pc", bus.imem_pc, 32'h60);
        drive(1'b1, 1'b0, 32'h14, 32'h6f);
        step();
        chk("hexit_halt", {31'd0, bus.halted}, 32'd0);
        chk("hexit_pc", bus.imem_pc, 32'h14);
        drive(1'b0, 1'b0, 32'h0, 32'h13);
        step();
        chk("run_pc", bus.imem_pc, 32'h18);
        chk("run_cnt", bus.fetch_count, 32'd7);

        drive(1'b1, 1'b0, 32'hFFFFFFFC, 32'h13);
        step();
        chk("wrap_pre", bus.imem_pc, 32'hFFFFFFFC);
        drive(1'b0, 1'b0, 32'h0, 32'h13);
        step();
        chk("wrap_pc", bus.imem_pc, 32'h0);
        chk("wrap_idpc", bus.if_id_pc, 32'hFFFFFFFC);
        chk("wrap_cnt", bus.fetch_count, 32'd8);

        drive(1'b1, 1'b0, 32'h80, 32'h13);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h6f);
        step();
        chk("h2_halt", {31'd0, bus.halted}, 32'd1);
        chk("h2_pc", bus.imem_pc, 32'h80);
        chk("h2_cnt", bus.fetch_count, 32'd9);
        rst = 1'b1;
        drive(1'b1, 1'b1, 32'h44, 32'h6f);
        step();
        chk_reset("rsth");
        rst = 1'b0;

        drive(1'b0, 1'b0, 32'h0, 32'h13);
        @(negedge clk);
        force dut.r_fetch_count = 32'hFFFFFFFE;
        #1;
        release dut.r_fetch_count;
        step();
        chk("sat_inc", bus.fetch_count, 32'hFFFFFFFF);
        step();
        chk("sat_hold", bus.fetch_count, 32'hFFFFFFFF);
        chk("sat_pc", bus.imem_pc, 32'h8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
